// File: rtl/serial_tx_if.sv
// serial_tx_if: load/word request and serial line status for serial_tx.
// Ports: load, in[WIDTH] (requester to tx); out, busy, done (tx to requester).
interface serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] in;
    logic             out;
    logic             busy;
    logic             done;

    modport master (
        output load,
        output in,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  in,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: framed parallel-in serial-out transmitter (start, LSB-first data, stop).
// Ports: clk, reset (sync, active-high), bus (slave: load, in -> out, busy, done).
module serial_tx #(
    parameter int WIDTH          = 8,
    parameter int CYCLES_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CYCLES_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;

    // With one cycle per bit DIV_LAST is 0, so every edge is a bit advance.
    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            div_q   <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Shift register content is meaningless outside a frame, so no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                out_d  = 1'b1;
                busy_d = 1'b0;
                div_d  = '0;
                if (bus.load) begin
                    shreg_d = bus.in;
                    state_d = START;
                    out_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    state_d = DATA;
                    out_d   = shreg_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        out_d   = 1'b1;
                    end else begin
                        // Next bit comes from the already-shifted word so
                        // WIDTH=1 never indexes past bit 0.
                        shreg_d = shreg_q >> 1;
                        out_d   = shreg_d[0];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                div_d = tick ? '0 : div_q + 1'b1;
                out_d = 1'b1;
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    div_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: random and directed frames against a line-level reference model.
// Two DUTs: CYCLES_PER_BIT=4 (a) and CYCLES_PER_BIT=1 (b), WIDTH=8.
module tb_serial_tx;
    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         la    = 1'b0;
    logic         lb    = 1'b0;
    logic [W-1:0] ia    = '0;
    logic [W-1:0] ib    = '0;

    serial_tx_if #(.WIDTH(W)) a_if ();
    serial_tx_if #(.WIDTH(W)) b_if ();

    assign a_if.load = la;
    assign a_if.in   = ia;
    assign b_if.load = lb;
    assign b_if.in   = ib;

    serial_tx #(.WIDTH(W), .CYCLES_PER_BIT(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    serial_tx #(.WIDTH(W), .CYCLES_PER_BIT(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_a = 0;
    int done_b = 0;
    int exp_done_a = 0;
    int exp_done_b = 0;
    bit sel = 1'b0;

    always @(negedge clk) begin
        if (a_if.done === 1'b1) done_a++;
        if (b_if.done === 1'b1) done_b++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Line level t cycles after the accepting edge.
    function automatic logic exp_line(input logic [W-1:0] w, input int t,
                                      input int c);
        int b;
        b = t / c;
        if (b == 0) return 1'b0;
        if (b <= W) return w[b-1];
        return 1'b1;
    endfunction

    function automatic int cur_cpb();
        return sel ? 1 : 4;
    endfunction

    function automatic logic cur_out();
        return sel ? b_if.out : a_if.out;
    endfunction

    function automatic logic cur_busy();
        return sel ? b_if.busy : a_if.busy;
    endfunction

    function automatic logic cur_done();
        return sel ? b_if.done : a_if.done;
    endfunction

    task automatic drv(input logic l, input logic [W-1:0] w);
        if (sel) begin
            lb = l;
            ib = w;
        end else begin
            la = l;
            ia = w;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_out", 32'(cur_out()), 32'd1);
            check("idle_busy", 32'(cur_busy()), 32'd0);
            check("idle_done", 32'(cur_done()), 32'd0);
        end
    endtask

    // mode 0: one-cycle load; 1: random load/in noise during the frame
    // (forced load at cycle 10); 2: load held with in=nxt for back-to-back.
    task automatic frame(input logic [W-1:0] w, input int mode,
                         input logic [W-1:0] nxt, input int abort_at);
        int c;
        c = cur_cpb();
        drv(1'b1, w);
        step();
        if (mode == 2) drv(1'b1, nxt);
        else drv(1'b0, '0);
        for (int t = 0; t < (W + 2) * c; t++) begin
            check("line", 32'(cur_out()), 32'(exp_line(w, t, c)));
            check("busy", 32'(cur_busy()), 32'd1);
            check("done_low", 32'(cur_done()), 32'd0);
            if (t == abort_at) begin
                reset = 1'b1;
                step();
                check("rst_out", 32'(cur_out()), 32'd1);
                check("rst_busy", 32'(cur_busy()), 32'd0);
                check("rst_done", 32'(cur_done()), 32'd0);
                reset = 1'b0;
                drv(1'b0, '0);
                idle(2);
                return;
            end
            if (mode == 1)
                drv((t == 10) || ($urandom_range(0, 1) == 1), W'($urandom));
            step();
        end
        check("done_pulse", 32'(cur_done()), 32'd1);
        check("end_busy", 32'(cur_busy()), 32'd0);
        check("end_out", 32'(cur_out()), 32'd1);
        if (sel) exp_done_b++;
        else exp_done_a++;
        if (mode != 2) drv(1'b0, '0);
    endtask

    task automatic random_frames(input int n);
        logic [W-1:0] w;
        logic [W-1:0] nxt;
        int m;
        nxt = W'($urandom);
        for (int i = 0; i < n; i++) begin
            w   = nxt;
            nxt = W'($urandom);
            m   = $urandom_range(0, 2);
            frame(w, m, nxt, -1);
        end
        drv(1'b0, '0);
        idle(3);
    endtask

    initial begin
        reset = 1'b1;
        la = 1'b1;
        ia = 8'hFF;
        lb = 1'b1;
        ib = 8'hFF;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_a_out", 32'(a_if.out), 32'd1);
            check("rst_a_busy", 32'(a_if.busy), 32'd0);
            check("rst_a_done", 32'(a_if.done), 32'd0);
            check("rst_b_out", 32'(b_if.out), 32'd1);
            check("rst_b_busy", 32'(b_if.busy), 32'd0);
        end
        la = 1'b0;
        lb = 1'b0;
        reset = 1'b0;
        idle(5);
        check("rst_b_idle", 32'(b_if.busy), 32'd0);

        sel = 1'b0;
        frame(8'hA5, 0, 8'h00, -1);
        idle(2);
        frame(8'h3C, 1, 8'h00, -1);
        idle(2);
        frame(8'h01, 2, 8'h80, -1);
        frame(8'h80, 0, 8'h00, -1);
        idle(2);
        frame(8'h55, 0, 8'h00, 15);
        frame(8'hC3, 0, 8'h00, -1);
        idle(2);
        random_frames(8);

        sel = 1'b1;
        frame(8'h00, 0, 8'h00, -1);
        frame(8'hFF, 0, 8'h00, -1);
        idle(2);
        frame(8'h5A, 2, 8'hE7, -1);
        frame(8'hE7, 0, 8'h00, -1);
        idle(1);
        random_frames(10);

        idle(2);
        check("done_count_a", 32'(done_a), 32'(exp_done_a));
        check("done_count_b", 32'(done_b), 32'(exp_done_b));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
